data_mem: RTL and testbench

DATA_MEM -- requirements
Module: data_mem

---
 rtl/data_mem_pkg.sv | 44 ++++
 rtl/data_mem_lane.sv | 43 ++++
 rtl/data_mem.sv | 60 ++++++
 tb/tb_data_mem.sv | 294 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/data_mem_pkg.sv
// Shared constants for the datapath: opcode/func fields and the data-memory access modes.
// The controller drives DMSel with the DM_* names defined here.
package data_mem_pkg;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_LH    = 6'b100001;
    localparam logic [5:0] OP_LHU   = 6'b100101;
    localparam logic [5:0] OP_LB    = 6'b100000;
    localparam logic [5:0] OP_LBU   = 6'b100100;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_SH    = 6'b101001;
    localparam logic [5:0] OP_SB    = 6'b101000;

    localparam logic [5:0] FUNC_ADDU = 6'b100001;
    localparam logic [5:0] FUNC_SUBU = 6'b100011;
    localparam logic [5:0] FUNC_JR   = 6'b001000;

    localparam logic [2:0] DM_W  = 3'b000;
    localparam logic [2:0] DM_H  = 3'b001;
    localparam logic [2:0] DM_HU = 3'b011;
    localparam logic [2:0] DM_B  = 3'b010;
    localparam logic [2:0] DM_BU = 3'b100;

    typedef enum logic [1:0] {
        ACC_WORD = 2'd0,
        ACC_HALF = 2'd1,
        ACC_BYTE = 2'd2
    } acc_width_e;

    // Unlisted encodings fall back to a full-word access.
    function automatic acc_width_e dm_width(input logic [2:0] sel);
        case (sel)
            DM_H, DM_HU: return ACC_HALF;
            DM_B, DM_BU: return ACC_BYTE;
            default:     return ACC_WORD;
        endcase
    endfunction

    function automatic logic dm_is_signed(input logic [2:0] sel);
        return (sel == DM_H) || (sel == DM_B);
    endfunction

endpackage

// File: rtl/data_mem_lane.sv
// dm_lane: combinational lane logic for the data memory -- store-merge of wd into the
// old word and load-extract with sign/zero extension. Low address bits select the lane.
module dm_lane
    import data_mem_pkg::*;
(
    input  logic [31:0] old_word_i,
    input  logic [31:0] wd_i,
    input  logic [2:0]  dm_sel_i,
    input  logic [1:0]  lane_i,
    output logic [31:0] new_word_o,
    output logic [31:0] rd_o
);

    acc_width_e  width;
    logic        sext;
    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    // Misaligned halves/words simply ignore the low address bits they do not use.
    always_comb begin
        width      = dm_width(dm_sel_i);
        sext       = dm_is_signed(dm_sel_i);
        byte_sel   = old_word_i[{lane_i, 3'b000} +: 8];
        half_sel   = old_word_i[{lane_i[1], 4'b0000} +: 16];
        new_word_o = old_word_i;
        rd_o       = old_word_i;
        case (width)
            ACC_HALF: begin
                new_word_o[{lane_i[1], 4'b0000} +: 16] = wd_i[15:0];
                rd_o = sext ? {{16{half_sel[15]}}, half_sel} : {16'h0000, half_sel};
            end
            ACC_BYTE: begin
                new_word_o[{lane_i, 3'b000} +: 8] = wd_i[7:0];
                rd_o = sext ? {{24{byte_sel[7]}}, byte_sel} : {24'h000000, byte_sel};
            end
            default: begin
                new_word_o = wd_i;
                rd_o       = old_word_i;
            end
        endcase
    end

endmodule

// File: rtl/data_mem.sv
// data_mem: word-organised data memory with combinational reads and byte/half/word stores.
// Define DM_DISPLAY_EN to print a trace line for every performed write.
module data_mem
    import data_mem_pkg::*;
#(
    parameter int DEPTH = 3072
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] pc,
    input  logic [31:0] addr,
    input  logic [31:0] wd,
    input  logic        we,
    input  logic [2:0]  dm_sel,
    output logic [31:0] rd
);

    logic [31:0] mem_q [DEPTH];
    logic [11:0] idx;
    logic        in_range;
    logic [31:0] cur_word;
    logic [31:0] merged_d;
    logic [31:0] lane_rd;

    assign idx      = addr[13:2];
    assign in_range = int'({20'h00000, idx}) < DEPTH;
    assign cur_word = in_range ? mem_q[idx] : 32'h0000_0000;

    dm_lane u_lane (
        .old_word_i (cur_word),
        .wd_i       (wd),
        .dm_sel_i   (dm_sel),
        .lane_i     (addr[1:0]),
        .new_word_o (merged_d),
        .rd_o       (lane_rd)
    );

    // No bypass: a same-cycle store becomes visible only after the edge.
    assign rd = in_range ? lane_rd : 32'h0000_0000;

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= 32'h0000_0000;
            end
        end else if (we && in_range) begin
            mem_q[idx] <= merged_d;
`ifdef DM_DISPLAY_EN
            $display("@%h: *%h <= %h", pc, {addr[31:2], 2'b00}, merged_d);
`endif
        end
    end

`ifdef DM_DISPLAY_EN
`else
    logic unused_trace_bits;
    assign unused_trace_bits = ^{pc, addr[31:14]};
`endif

endmodule

// File: tb/tb_data_mem.sv
// Self-checking bench for data_mem: directed vectors plus random traffic against a
// byte-addressed reference model.
module tb_data_mem;
    import data_mem_pkg::*;

    localparam int DEPTH = 3072;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] pc;
    logic [31:0] addr;
    logic [31:0] wd;
    logic        we;
    logic [2:0]  dm_sel;
    logic [31:0] rd;

    int total = 0;
    int bad   = 0;

    logic [7:0]  mb [DEPTH*4];
    logic [31:0] exp_q [$];

    always #5 clk = ~clk;

    data_mem #(.DEPTH(DEPTH)) dut (
        .clk    (clk),
        .reset  (reset),
        .pc     (pc),
        .addr   (addr),
        .wd     (wd),
        .we     (we),
        .dm_sel (dm_sel),
        .rd     (rd)
    );

    // ---------------- reference model (byte array, little-endian) ----------------
    function automatic int unsigned nbytes(input logic [2:0] sel);
        if (sel == 3'b001 || sel == 3'b011) return 2;
        if (sel == 3'b010 || sel == 3'b100) return 1;
        return 4;
    endfunction

    function automatic int unsigned first_byte(input logic [31:0] a, input logic [2:0] sel);
        int unsigned n;
        n = nbytes(sel);
        if (n == 4) return 0;
        if (n == 2) return a[1] ? 2 : 0;
        return int'(a[1:0]);
    endfunction

    function automatic logic [31:0] model_load(input logic [31:0] a, input logic [2:0] sel);
        int unsigned w, n, off;
        longint v;
        w   = int'(a[13:2]);
        n   = nbytes(sel);
        off = first_byte(a, sel);
        v   = 0;
        if (w >= DEPTH) return 32'h0;
        for (int k = 0; k < int'(n); k++)
            v = v + (longint'(mb[w*4 + off + k]) << (8*k));
        if ((sel == 3'b001 || sel == 3'b010) && v >= (longint'(1) << (8*n - 1)))
            v = v - (longint'(1) << (8*n));
        return v[31:0];
    endfunction

    task automatic model_store(input logic [31:0] a, input logic [31:0] d, input logic [2:0] sel);
        int unsigned w, n, off;
        w   = int'(a[13:2]);
        n   = nbytes(sel);
        off = first_byte(a, sel);
        if (w < DEPTH)
            for (int k = 0; k < int'(n); k++) mb[w*4 + off + k] = d[8*k +: 8];
    endtask

    task automatic model_reset();
        for (int i = 0; i < DEPTH*4; i++) mb[i] = 8'h00;
    endtask

    // ---------------- driver tasks ----------------
    task automatic drive_write(input logic [31:0] a, input logic [31:0] d, input logic [2:0] sel);
        @(negedge clk);
        addr = a; wd = d; dm_sel = sel; we = 1'b1; pc = 32'h0000_3000 + a;
        @(negedge clk);
        we = 1'b0;
        model_store(a, d, sel);
    endtask

    task automatic read_now(input logic [31:0] a, input logic [2:0] sel, output logic [31:0] d);
        @(negedge clk);
        addr = a; dm_sel = sel; we = 1'b0;
        #1 d = rd;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        logic [31:0] ra [5];
        logic [31:0] got;
        ra = '{32'h0, 32'h4, 32'h1236, 32'h2FFF, 32'h3000};
        reset = 1'b1; we = 1'b0; addr = 0; wd = 0; dm_sel = DM_W; pc = 0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        model_reset();
        for (int i = 0; i < 5; i++) begin
            for (int s = 0; s < 5; s++) begin
                read_now(ra[i], 3'(s), got);
                total++;
                if (got !== 32'h0) begin
                    bad++;
                    $display("FAIL reset_read a=%h sel=%0d: got %h expected 00000000", ra[i], s, got);
                end
            end
        end
    endtask

    task automatic test_spec_vectors();
        logic [31:0] ra [7];
        logic [2:0]  rs [7];
        logic [31:0] re [7];
        logic [31:0] got;
        drive_write(32'h4, 32'h1234_5678, DM_W);
        read_now(32'h4, DM_W, got);
        total++;
        if (got !== 32'h1234_5678) begin
            bad++;
            $display("FAIL sw_lw: got %h expected 12345678", got);
        end
        drive_write(32'h6, 32'h0000_00AB, DM_B);
        drive_write(32'hA, 32'h0000_BEEF, DM_H);
        ra = '{32'h4, 32'h6, 32'h6, 32'h8, 32'hA, 32'hA, 32'h8};
        rs = '{DM_W, DM_B, DM_BU, DM_W, DM_H, DM_HU, DM_HU};
        re = '{32'h12AB_5678, 32'hFFFF_FFAB, 32'h0000_00AB, 32'hBEEF_0000,
               32'hFFFF_BEEF, 32'h0000_BEEF, 32'h0000_0000};
        for (int i = 0; i < 7; i++) begin
            read_now(ra[i], rs[i], got);
            total++;
            if (got !== re[i]) begin
                bad++;
                $display("FAIL vector%0d a=%h sel=%0d: got %h expected %h", i, ra[i], rs[i], got, re[i]);
            end
        end
    endtask

    task automatic test_misaligned();
        logic [31:0] ra [5];
        logic [2:0]  rs [5];
        logic [31:0] re [5];
        logic [31:0] got;
        drive_write(32'h7, 32'hCAFE_F00D, DM_W);
        drive_write(32'hB, 32'h5555_1234, DM_H);
        ra = '{32'h4, 32'h7, 32'h8, 32'h9, 32'hB};
        rs = '{DM_W, DM_W, DM_W, DM_H, DM_HU};
        re = '{32'hCAFE_F00D, 32'hCAFE_F00D, 32'h1234_0000, 32'h0000_0000, 32'h0000_1234};
        for (int i = 0; i < 5; i++) begin
            read_now(ra[i], rs[i], got);
            total++;
            if (got !== re[i]) begin
                bad++;
                $display("FAIL misaligned%0d a=%h: got %h expected %h", i, ra[i], got, re[i]);
            end
        end
    endtask

    task automatic test_out_of_range();
        logic [31:0] got;
        drive_write(32'h2FFC, 32'hA5A5_A5A5, DM_W);
        drive_write(32'h3000, 32'h1111_2222, DM_W);
        drive_write(32'h3FFF, 32'h0000_0077, DM_B);
        read_now(32'h2FFC, DM_W, got);
        total++;
        if (got !== 32'hA5A5_A5A5) begin
            bad++;
            $display("FAIL last_word: got %h expected a5a5a5a5", got);
        end
        read_now(32'h3000, DM_W, got);
        total++;
        if (got !== 32'h0) begin
            bad++;
            $display("FAIL oor_lw: got %h expected 00000000", got);
        end
        read_now(32'h3FFF, DM_BU, got);
        total++;
        if (got !== 32'h0) begin
            bad++;
            $display("FAIL oor_lbu: got %h expected 00000000", got);
        end
        read_now(32'h0, DM_W, got);
        total++;
        if (got !== 32'h0) begin
            bad++;
            $display("FAIL oor_alias: got %h expected 00000000", got);
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] old_v, new_v, got;
        old_v = model_load(32'h10, DM_W);
        @(negedge clk);
        addr = 32'h10; wd = 32'h55AA_55AA; dm_sel = DM_W; we = 1'b1;
        #1;
        total++;
        if (rd !== old_v) begin
            bad++;
            $display("FAIL no_bypass: got %h expected %h", rd, old_v);
        end
        model_store(32'h10, 32'h55AA_55AA, DM_W);
        new_v = model_load(32'h10, DM_W);
        @(posedge clk);
        #1;
        total++;
        if (rd !== new_v) begin
            bad++;
            $display("FAIL after_edge: got %h expected %h", rd, new_v);
        end
        // consecutive byte stores into the same word on adjacent edges
        @(negedge clk);
        addr = 32'h20; wd = 32'h0000_0011; dm_sel = DM_B; we = 1'b1;
        @(negedge clk);
        addr = 32'h21; wd = 32'h0000_0022;
        @(negedge clk);
        addr = 32'h23; wd = 32'h0000_0044; dm_sel = DM_BU;
        @(negedge clk);
        we = 1'b0;
        model_store(32'h20, 32'h11, DM_B);
        model_store(32'h21, 32'h22, DM_B);
        model_store(32'h23, 32'h44, DM_BU);
        read_now(32'h20, DM_W, got);
        total++;
        if (got !== 32'h4400_2211) begin
            bad++;
            $display("FAIL b2b_merge: got %h expected 44002211", got);
        end
    endtask

    task automatic test_reset_with_write();
        logic [31:0] ra [4];
        logic [31:0] re [4];
        logic [31:0] got;
        @(negedge clk);
        reset = 1'b1; we = 1'b1; addr = 32'h4; wd = 32'hDEAD_BEEF; dm_sel = DM_W;
        @(negedge clk);
        reset = 1'b0; addr = 32'hC; wd = 32'h600D_F00D;
        model_reset();
        @(negedge clk);
        we = 1'b0;
        model_store(32'hC, 32'h600D_F00D, DM_W);
        ra = '{32'h4, 32'h2FFC, 32'h20, 32'hC};
        re = '{32'h0, 32'h0, 32'h0, 32'h600D_F00D};
        for (int i = 0; i < 4; i++) begin
            read_now(ra[i], DM_W, got);
            total++;
            if (got !== re[i]) begin
                bad++;
                $display("FAIL reset_we%0d a=%h: got %h expected %h", i, ra[i], got, re[i]);
            end
        end
    endtask

    task automatic test_random();
        logic [31:0] a, d, got, e;
        logic [2:0]  s;
        for (int n = 0; n < 400; n++) begin
            if ($urandom_range(0, 9) < 7) a = 32'($urandom_range(0, 32'h3F));
            else                          a = 32'($urandom_range(32'h2FC0, 32'h303F));
            s = 3'($urandom_range(0, 7));
            if ($urandom_range(0, 1) == 1) begin
                d = $urandom;
                drive_write(a, d, s);
            end else begin
                exp_q.push_back(model_load(a, s));
                read_now(a, s, got);
                e = exp_q.pop_front();
                total++;
                if (got !== e) begin
                    bad++;
                    $display("FAIL random a=%h sel=%0d: got %h expected %h", a, s, got, e);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_spec_vectors();
        test_misaligned();
        test_out_of_range();
        test_back_to_back();
        test_reset_with_write();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
